// File: rtl/ram_cmd_arbiter.sv
// ----------------------------------------------------------------------------
// ram_cmd_arbiter
//
// Two-port transaction arbiter in front of a command-driven RAM. Each port
// raises req with an operation (we, addr, wdata) and holds it until gnt.
// The winning transaction becomes a short burst of RAM command words
// ({opcode[1:0], payload}) on ram_din qualified by ram_rx_valid:
//   write : 00 addr, 01 wdata                      -> done 3 cycles after gnt
//   read  : 10 addr, 11 0, then wait for ram_tx_valid -> done 4+ cycles after gnt
// A read that sees no ram_tx_valid within TIMEOUT wait cycles completes with
// err=1 and rdata=0.
//
// Ports
//   clk, rst             : clock, asynchronous active-high reset
//   req_x/we_x/addr_x/wdata_x : per-port request and operation (x = a, b)
//   gnt_x                : combinational accept strobe (IDLE only)
//   done_x               : registered one-cycle completion pulse
//   rdata, err           : read result / read-timeout flag for the done pulse
//   busy                 : a transaction is in progress
//   ram_din, ram_rx_valid: command word and strobe towards the RAM
//   ram_tx_valid, ram_dout : read-data return from the RAM
//
// Build option
//   RAM_ARB_RR_EN : round-robin between simultaneous requests. When left
//                   undefined, port A has fixed priority.
// ----------------------------------------------------------------------------
module ram_cmd_arbiter #(
    parameter int ADDR_SIZE = 8,
    parameter int TIMEOUT   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_a,
    input  logic                 req_b,
    input  logic                 we_a,
    input  logic                 we_b,
    input  logic [ADDR_SIZE-1:0] addr_a,
    input  logic [ADDR_SIZE-1:0] addr_b,
    input  logic [ADDR_SIZE-1:0] wdata_a,
    input  logic [ADDR_SIZE-1:0] wdata_b,
    output logic                 gnt_a,
    output logic                 gnt_b,
    output logic                 done_a,
    output logic                 done_b,
    output logic [ADDR_SIZE-1:0] rdata,
    output logic                 err,
    output logic                 busy,
    output logic [ADDR_SIZE+1:0] ram_din,
    output logic                 ram_rx_valid,
    input  logic                 ram_tx_valid,
    input  logic [ADDR_SIZE-1:0] ram_dout
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] WADDR = 3'd1;
    localparam logic [2:0] WDATA = 3'd2;
    localparam logic [2:0] RADDR = 3'd3;
    localparam logic [2:0] RDATA = 3'd4;
    localparam logic [2:0] RWAIT = 3'd5;

    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [2:0]           state;
    logic [2:0]           state_nxt;
    logic                 owner_b;
    logic [ADDR_SIZE-1:0] op_addr;
    logic [ADDR_SIZE-1:0] op_wdata;
    logic [CNT_W-1:0]     wait_cnt;
    logic                 grant_ok;
    logic                 pick_b;
    logic                 rw_hit;
    logic                 rw_tout;
    logic                 finish;

    // Grants are only offered in IDLE, and are suppressed while reset is
    // held so that every output reads 0 during reset.
    assign grant_ok = (state == IDLE) && !rst;

`ifdef RAM_ARB_RR_EN
    // last_b remembers which port won the previous grant; on a tie the
    // other port wins. It resets to B so that A wins the first tie.
    logic last_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_b <= 1'b1;
        end else if (gnt_a || gnt_b) begin
            last_b <= gnt_b;
        end
    end

    assign pick_b = req_b && (!req_a || !last_b);
`else
    assign pick_b = req_b && !req_a;
`endif

    assign gnt_a = grant_ok && req_a && !pick_b;
    assign gnt_b = grant_ok && pick_b;
    assign busy  = (state != IDLE);

    // A read leaves RWAIT either on returned data or once the wait counter
    // has seen TIMEOUT empty cycles; data in the final cycle still counts.
    assign rw_hit  = (state == RWAIT) && ram_tx_valid;
    assign rw_tout = (state == RWAIT) && !ram_tx_valid && (wait_cnt == CNT_LAST);
    assign finish  = (state == WDATA) || rw_hit || rw_tout;

    // Next-state and RAM command word. IDLE and RWAIT drive an all-zero
    // word so the RAM never sees a stray opcode 11 between commands.
    always_comb begin
        state_nxt    = state;
        ram_din      = '0;
        ram_rx_valid = 1'b0;
        case (state)
            IDLE: begin
                if (gnt_a) begin
                    state_nxt = we_a ? WADDR : RADDR;
                end else if (gnt_b) begin
                    state_nxt = we_b ? WADDR : RADDR;
                end
            end
            WADDR: begin
                ram_din      = {2'b00, op_addr};
                ram_rx_valid = 1'b1;
                state_nxt    = WDATA;
            end
            WDATA: begin
                ram_din      = {2'b01, op_wdata};
                ram_rx_valid = 1'b1;
                state_nxt    = IDLE;
            end
            RADDR: begin
                ram_din      = {2'b10, op_addr};
                ram_rx_valid = 1'b1;
                state_nxt    = RDATA;
            end
            RDATA: begin
                ram_din      = {2'b11, {ADDR_SIZE{1'b0}}};
                ram_rx_valid = 1'b1;
                state_nxt    = RWAIT;
            end
            RWAIT: begin
                if (rw_hit || rw_tout) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, latched operation and completion outputs. The operation is
    // latched only on a grant, so a grant in the same cycle as a done pulse
    // leaves that pulse, err and rdata untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            owner_b  <= 1'b0;
            op_addr  <= '0;
            op_wdata <= '0;
            wait_cnt <= '0;
            done_a   <= 1'b0;
            done_b   <= 1'b0;
            err      <= 1'b0;
            rdata    <= '0;
        end else begin
            state <= state_nxt;
            if (gnt_a) begin
                owner_b  <= 1'b0;
                op_addr  <= addr_a;
                op_wdata <= wdata_a;
            end else if (gnt_b) begin
                owner_b  <= 1'b1;
                op_addr  <= addr_b;
                op_wdata <= wdata_b;
            end
            if ((state == RWAIT) && !rw_hit && !rw_tout) begin
                wait_cnt <= wait_cnt + 1'b1;
            end else begin
                wait_cnt <= '0;
            end
            done_a <= finish && !owner_b;
            done_b <= finish && owner_b;
            err    <= rw_tout;
            if (rw_hit) begin
                rdata <= ram_dout;
            end else if (rw_tout) begin
                rdata <= '0;
            end
        end
    end

endmodule
